rv32_muldiv_iter: RTL
=====================

// Module: rv32_muldiv_iter
// PURPOSE
//  Iterative RV32 M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU selected by funct3.
//  Sits beside the ALU in execute; takes one op at a time over a valid/ready handshake.
//  Returns the result with its rd tag after a fixed, parameter-defined number of cycles.
//  Width and bits-per-cycle are parametrised; handles divide-by-zero/overflow per the RV32 spec.
// PARAMETERS
//  XLEN    32  operand/result width; even, >=8
//  UNROLL  1   bits retired per CALC cycle; must divide XLEN (1,2,4,8)
//  TAGW    5   width of destination-register tag (rv32_isa::RegAddrWidth)
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     async active-low reset
//  i_valid     in   1     request valid
//  o_ready     out  1     unit can accept a request (=state IDLE)
//  i_funct3    in   3     op select, rv32_isa::OpF3MUL..OpF3REMU encoding
//  i_rs1       in   XLEN  operand A (multiplicand / dividend)
//  i_rs2       in   XLEN  operand B (multiplier / divisor)
//  i_rd        in   TAGW  destination tag, returned unchanged
//  i_flush     in   1     abort any op in flight (pipeline flush)
//  o_valid     out  1     result valid
//  i_ready     in   1     consumer accepts result
//  o_result    out  XLEN  result
//  o_rd        out  TAGW  tag of o_result
//  o_busy      out  1     state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, o_valid=0, o_result=0, o_rd=0, counter=0; o_ready=1 once in IDLE.
//  FSM IDLE -> CALC -> FIX -> DONE -> IDLE; IDLE -> FIX directly for special cases.
//  IDLE: accept on i_valid&o_ready; latch funct3, rd, |A|,|B| and sign flags per op:
//   MUL/MULH/DIV/REM signed both; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned.
//  CALC: XLEN/UNROLL cycles exactly. MUL*: shift-add, 2*XLEN product accumulator.
//   DIV*: restoring division, UNROLL quotient bits per cycle, XLEN+1-bit partial remainder.
//  FIX (1 cycle): apply sign, select result into o_result/o_rd; o_valid=1 on entry to DONE.
//   MUL -> low XLEN of product; MULH* -> high XLEN of signed-corrected 2*XLEN product.
//   DIV: negate quotient if signs differ; REM: remainder takes sign of dividend.
//  Special cases (detected in IDLE at accept, skip CALC):
//   divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
//   DIV signed overflow (rs1=1<<(XLEN-1), rs2=-1): DIV -> rs1; REM -> 0.
//  Latency: normal op o_valid rises XLEN/UNROLL+2 edges after accepting edge; special case 2 edges.
//  DONE: hold o_valid, o_result, o_rd stable until i_ready; on o_valid&i_ready -> IDLE, o_valid=0.
//   o_ready low in DONE: no same-cycle accept; next op accepted the cycle after retire.
//  i_flush: any state -> IDLE next edge, o_valid=0, no result emitted; flush with i_valid in IDLE
//   drops the request (flush wins). Result visible in DONE with i_ready=1 and i_flush=1: not retired.
//  Unknown funct3 impossible (3-bit fully decoded). Operands/funct3 ignored outside accept.
//  Reset mid-operation: immediate return to reset state; in-flight op lost.
// TESTING
//  MUL 7 * -3 (0xFFFFFFFD) -> 0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; o_valid after 2 edges.
//  Latency/backpressure, UNROLL=1 and 4: o_valid at edge 34 / 10; hold i_ready=0 5 cycles -> outputs stable, o_ready=0.
//  i_flush mid-CALC and rst_n low mid-CALC -> IDLE next cycle, no o_valid; next op result correct with own rd tag.

Source files
------------

// File: rtl/rv32_muldiv_iter.sv
// Iterative RV32 M-extension multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up in a single FIX cycle.
module rv32_muldiv_iter #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1,
    parameter int TAGW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [TAGW-1:0] i_rd,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [TAGW-1:0] o_rd,
    output logic            o_busy
);

    localparam int NSTEP = XLEN / UNROLL;
    localparam int CW    = $clog2(NSTEP + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(NSTEP - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic [TAGW-1:0]   r_rd_lat;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [XLEN-1:0]   r_opb;
    logic [2*XLEN-1:0] r_acc;
    logic              r_special;
    logic [XLEN-1:0]   r_spec_val;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;
    logic [TAGW-1:0]   r_rd;

    logic              w_accept;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_val;
    logic [2*XLEN-1:0] w_stage [0:UNROLL];
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_val;

    assign o_ready  = (r_state == S_IDLE);
    assign o_busy   = (r_state != S_IDLE);
    assign o_valid  = r_valid;
    assign o_result = r_result;
    assign o_rd     = r_rd;

    assign w_accept = i_valid && (r_state == S_IDLE) && !i_flush;

    // Signedness of each operand as a function of the opcode.
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sa = i_rs1[XLEN-1];
                w_sb = i_rs2[XLEN-1];
            end
            3'b010: w_sa = i_rs1[XLEN-1];
            default: ;
        endcase
    end

    assign w_abs_a = w_sa ? (~i_rs1 + 1'b1) : i_rs1;
    assign w_abs_b = w_sb ? (~i_rs2 + 1'b1) : i_rs2;

    assign w_b_zero  = i_funct3[2] && (i_rs2 == '0);
    assign w_ovf     = i_funct3[2] && !i_funct3[0] && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    assign w_special = w_b_zero || w_ovf;

    always_comb begin
        w_spec_val = '0;
        if (w_b_zero)
            w_spec_val = i_funct3[1] ? i_rs1 : '1;
        else if (w_ovf)
            w_spec_val = i_funct3[1] ? '0 : i_rs1;
    end

    // One multiply or divide step per stage; r_acc holds {hi, lo}.
    // Multiply: hi = partial sum, lo = remaining multiplier bits.
    // Divide:   hi = partial remainder, lo = dividend shifting into quotient.
    assign w_stage[0] = r_acc;
    generate
        for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
            logic [XLEN:0]     w_sum;
            logic [XLEN:0]     w_rsh;
            logic [XLEN:0]     w_diff;
            logic [2*XLEN-1:0] w_mul_nx;
            logic [2*XLEN-1:0] w_div_nx;

            assign w_sum    = {1'b0, w_stage[gi][2*XLEN-1:XLEN]}
                              + (w_stage[gi][0] ? {1'b0, r_opb} : '0);
            assign w_mul_nx = {w_sum, w_stage[gi][XLEN-1:1]};

            assign w_rsh    = {w_stage[gi][2*XLEN-1:XLEN], w_stage[gi][XLEN-1]};
            assign w_diff   = w_rsh - {1'b0, r_opb};
            assign w_div_nx = w_diff[XLEN]
                ? {w_rsh[XLEN-1:0], w_stage[gi][XLEN-2:0], 1'b0}
                : {w_diff[XLEN-1:0], w_stage[gi][XLEN-2:0], 1'b1};

            assign w_stage[gi+1] = r_f3[2] ? w_div_nx : w_mul_nx;
        end
    endgenerate

    assign w_prod = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    assign w_rem  = r_sign_a ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_val = '0;
        if (r_special)
            w_fix_val = r_spec_val;
        else if (r_f3 == 3'b000)
            w_fix_val = w_prod[XLEN-1:0];
        else if (!r_f3[2])
            w_fix_val = w_prod[2*XLEN-1:XLEN];
        else if (r_f3[1])
            w_fix_val = w_rem;
        else
            w_fix_val = w_quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_f3       <= '0;
            r_rd_lat   <= '0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_valid    <= 1'b0;
            r_result   <= '0;
            r_rd       <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f3       <= i_funct3;
                        r_rd_lat   <= i_rd;
                        r_sign_a   <= w_sa;
                        r_sign_b   <= w_sb;
                        r_special  <= w_special;
                        r_spec_val <= w_spec_val;
                        r_cnt      <= '0;
                        if (i_funct3[2]) begin
                            r_opb <= w_abs_b;
                            r_acc <= {{XLEN{1'b0}}, w_abs_a};
                        end else begin
                            r_opb <= w_abs_a;
                            r_acc <= {{XLEN{1'b0}}, w_abs_b};
                        end
                        r_state <= w_special ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_stage[UNROLL];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_val;
                    r_rd     <= r_rd_lat;
                    r_valid  <= 1'b1;
                    r_state  <= S_DONE;
                end
                default: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
